// File: rtl/ram_frame_writer_pkg.sv
// Shared types and helpers for the UART-to-frame-RAM writer.
// Pure declarations, no logic, no flow control.
package ram_frame_writer_pkg;

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        WRITE,
        FRAME_END
    } state_e;

    localparam int BYTE_WIDTH = 8;

    function automatic int bytes_per_word(input int width);
        return width / BYTE_WIDTH;
    endfunction

endpackage

// File: rtl/rx_timeout.sv
// Idle counter: expired pulses after CYCLES-1 enabled cycles with no kick.
// Combinational pulse from a registered count; never stalls its caller.
module rx_timeout #(
    parameter int CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    input  logic kick,
    output logic expired
);

    localparam int CW = (CYCLES > 1) ? $clog2(CYCLES) : 1;

    logic [CW-1:0] cnt_q;

    assign expired = enable && !kick && (cnt_q == CW'(CYCLES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (kick || !enable || expired) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

endmodule

// File: rtl/ram_frame_writer.sv
// Packs UART bytes MSB-first into RAM words; write strobe 1 cycle after the last byte, no backpressure.
// RAM_FRAME_WRITER_CHECKSUM_EN adds a per-frame mod-256 byte sum on frame_checksum.
module ram_frame_writer
    import ram_frame_writer_pkg::*;
#(
    parameter  int RAM_WIDTH      = 32,
    parameter  int RAM_DEPTH      = (480 * 360 * 24) / RAM_WIDTH,
    parameter  int TIMEOUT_CYCLES = 1000000,
    localparam int BYTES_PER_WORD = bytes_per_word(RAM_WIDTH),
    localparam int ADRESS_BITS    = $clog2(RAM_DEPTH)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [BYTE_WIDTH-1:0]  rx_data,
    input  logic                   rx_ready,
    input  logic                   clear,
    output logic                   write_enable,
    output logic [ADRESS_BITS-1:0] write_adress,
    output logic [RAM_WIDTH-1:0]   write_data,
    output logic                   frame_done
`ifdef RAM_FRAME_WRITER_CHECKSUM_EN
    ,
    output logic [7:0]             frame_checksum
`endif
);

    localparam int CNT_W = $clog2(BYTES_PER_WORD + 1);

    state_e                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d, cnt_inc;
    logic [ADRESS_BITS-1:0] addr_q, addr_d;
    logic [RAM_WIDTH-1:0]   shift_q, shift_d;
    logic [RAM_WIDTH-1:0]   wdata_q, wdata_d;
    logic                   we_q, done_q;
    logic                   expired;

    rx_timeout #(
        .CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .enable  (state_q == COLLECT),
        .kick    (rx_ready || clear),
        .expired (expired)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        shift_d = shift_q;
        wdata_d = wdata_q;
        cnt_inc = cnt_q + CNT_W'(1);

        case (state_q)
            COLLECT: begin
                if (expired) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end
            end
            WRITE: begin
                if (addr_q == ADRESS_BITS'(RAM_DEPTH - 1)) begin
                    addr_d  = '0;
                    state_d = FRAME_END;
                end else begin
                    addr_d  = addr_q + ADRESS_BITS'(1);
                    state_d = IDLE;
                end
            end
            FRAME_END: state_d = (cnt_q != '0) ? COLLECT : IDLE;
            default: ;
        endcase

        if (clear) begin
            state_d = IDLE;
            cnt_d   = '0;
            addr_d  = '0;
        end else if (rx_ready) begin
            shift_d = (shift_q << BYTE_WIDTH) | RAM_WIDTH'(rx_data);
            if (cnt_inc == CNT_W'(BYTES_PER_WORD)) begin
                cnt_d   = '0;
                wdata_d = shift_d;
                state_d = WRITE;
            end else begin
                cnt_d = cnt_inc;
                // A byte landing on the last write keeps the frame pulse; FRAME_END resumes COLLECT.
                if (state_d != FRAME_END) begin
                    state_d = COLLECT;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            shift_q <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            shift_q <= shift_d;
            wdata_q <= wdata_d;
            we_q    <= (state_d == WRITE);
            done_q  <= (state_d == FRAME_END);
        end
    end

    assign write_enable = we_q;
    assign write_adress = addr_q;
    assign write_data   = wdata_q;
    assign frame_done   = done_q;

`ifdef RAM_FRAME_WRITER_CHECKSUM_EN
    logic [7:0] sum_q, sum_d, chk_q, chk_d;

    function automatic logic [7:0] word_sum(input logic [RAM_WIDTH-1:0] w);
        logic [7:0] s;
        s = '0;
        for (int i = 0; i < BYTES_PER_WORD; i++) begin
            s = s + w[i*BYTE_WIDTH +: BYTE_WIDTH];
        end
        return s;
    endfunction

    always_comb begin
        sum_d = sum_q;
        chk_d = chk_q;
        if (state_q == WRITE) begin
            sum_d = sum_q + word_sum(wdata_q);
        end
        if (state_q == FRAME_END) begin
            chk_d = sum_q;
            sum_d = '0;
        end
        if (clear) begin
            sum_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_q <= '0;
            chk_q <= '0;
        end else begin
            sum_q <= sum_d;
            chk_q <= chk_d;
        end
    end

    assign frame_checksum = chk_q;
`endif

endmodule

// File: tb/tb_ram_frame_writer.sv
// Bench for ram_frame_writer with a 4-word frame and 16-cycle timeout.
module tb_ram_frame_writer;

    localparam int W   = 32;
    localparam int D   = 4;
    localparam int TO  = 16;
    localparam int BPW = W / 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rx_ready = 1'b0;
    logic        clear = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        write_enable;
    logic [1:0]  write_adress;
    logic [31:0] write_data;
    logic        frame_done;
`ifdef RAM_FRAME_WRITER_CHECKSUM_EN
    logic [7:0]  frame_checksum;
`endif

    always #5 clk = ~clk;

    ram_frame_writer #(
        .RAM_WIDTH      (W),
        .RAM_DEPTH      (D),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .rx_data      (rx_data),
        .rx_ready     (rx_ready),
        .clear        (clear),
        .write_enable (write_enable),
        .write_adress (write_adress),
        .write_data   (write_data),
        .frame_done   (frame_done)
`ifdef RAM_FRAME_WRITER_CHECKSUM_EN
        ,
        .frame_checksum (frame_checksum)
`endif
    );

    int checks = 0;
    int errors = 0;
    bit run = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Model: pending bytes of the word in progress, the address the next word goes to,
    // and what the outputs must show during the current cycle.
    logic [7:0]  partial[$];
    logic [1:0]  m_addr = '0;
    int          m_idle = 0;
    logic        m_we = 1'b0, m_fd = 1'b0, n_we, n_fd;
    logic [31:0] m_data = '0;
    logic [7:0]  m_sum = '0, m_chk = '0;

    function automatic logic [7:0] bytes_total(input logic [31:0] w);
        return w[31:24] + w[23:16] + w[15:8] + w[7:0];
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            partial.delete();
            m_addr = '0; m_idle = 0; m_we = 1'b0; m_fd = 1'b0;
            m_sum = '0; m_chk = '0;
        end else begin
            n_we = 1'b0;
            n_fd = 1'b0;
            if (m_fd) begin
                m_chk = m_sum;
                m_sum = '0;
            end
            if (m_we) begin
                if (!clear) m_sum = m_sum + bytes_total(m_data);
                n_fd   = !clear && (m_addr == 2'(D - 1));
                m_addr = (m_addr == 2'(D - 1)) ? 2'd0 : m_addr + 2'd1;
            end
            if (clear) begin
                m_addr = '0;
                partial.delete();
                m_idle = 0;
                m_sum  = '0;
            end else if (rx_ready) begin
                partial.push_back(rx_data);
                m_idle = 0;
                if (partial.size() == BPW) begin
                    m_data = '0;
                    for (int i = 0; i < BPW; i++) m_data = {m_data[23:0], partial[i]};
                    partial.delete();
                    n_we = 1'b1;
                end
            end else if (partial.size() != 0) begin
                m_idle++;
                if (m_idle == TO) begin
                    partial.delete();
                    m_idle = 0;
                end
            end
            m_we = n_we;
            m_fd = n_fd;
        end
    end

    logic [33:0] wr_log[$];
    int          fd_count = 0;

    always @(negedge clk) begin
        if (run && !rst) begin
            check("write_enable", 32'(write_enable), 32'(m_we));
            check("frame_done", 32'(frame_done), 32'(m_fd));
            check("write_adress", 32'(write_adress), 32'(m_addr));
            if (m_we) check("write_data", write_data, m_data);
`ifdef RAM_FRAME_WRITER_CHECKSUM_EN
            check("frame_checksum", 32'(frame_checksum), 32'(m_chk));
`endif
            if (write_enable) wr_log.push_back({write_adress, write_data});
            if (frame_done) fd_count++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        rx_ready = 1'b1;
        rx_data  = b;
        tick();
        rx_ready = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic do_reset();
        run = 1'b0;
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        run = 1'b1;
        wr_log.delete();
        fd_count = 0;
    endtask

    task automatic expect_log(input string name, input int idx, input logic [1:0] a, input logic [31:0] d);
        if (idx >= wr_log.size()) begin
            check({name, "_present"}, 32'(wr_log.size()), 32'(idx + 1));
        end else begin
            check({name, "_addr"}, 32'(wr_log[idx][33:32]), 32'(a));
            check({name, "_data"}, wr_log[idx][31:0], d);
        end
    endtask

    initial begin
        idle(2);
        @(negedge clk);
        check("rst_we", 32'(write_enable), 32'd0);
        check("rst_fd", 32'(frame_done), 32'd0);
        check("rst_addr", 32'(write_adress), 32'd0);
        check("rst_data", write_data, 32'd0);
`ifdef RAM_FRAME_WRITER_CHECKSUM_EN
        check("rst_chk", 32'(frame_checksum), 32'd0);
`endif
        @(posedge clk);
        #1;
        rst = 1'b0;
        run = 1'b1;

        // Single word
        send(8'h11); send(8'h22); send(8'h33); send(8'h44);
        idle(3);
        check("t1_writes", 32'(wr_log.size()), 32'd1);
        expect_log("t1_w0", 0, 2'd0, 32'h11223344);
        check("t1_next_addr", 32'(write_adress), 32'd1);

        // Partial word discarded after timeout
        do_reset();
        send(8'h01); send(8'h02);
        idle(20);
        send(8'hAA); send(8'hBB); send(8'hCC); send(8'hDD);
        idle(3);
        check("t2_writes", 32'(wr_log.size()), 32'd1);
        expect_log("t2_w0", 0, 2'd0, 32'hAABBCCDD);

        // Full frame, back-to-back bytes, then wrap into a second frame
        do_reset();
        for (int i = 1; i <= 16; i++) send(8'(i));
        idle(3);
        check("t3_writes", 32'(wr_log.size()), 32'd4);
        for (int i = 0; i < 4; i++) expect_log("t3_w", i, 2'(i), {8'(4*i+1), 8'(4*i+2), 8'(4*i+3), 8'(4*i+4)});
        check("t3_frames", 32'(fd_count), 32'd1);
`ifdef RAM_FRAME_WRITER_CHECKSUM_EN
        check("t3_chk1", 32'(frame_checksum), 32'h88);
`endif
        for (int i = 0; i < 16; i++) send(8'h02);
        idle(3);
        check("t3_writes2", 32'(wr_log.size()), 32'd8);
        expect_log("t3_wrap", 4, 2'd0, 32'h02020202);
        check("t3_frames2", 32'(fd_count), 32'd2);
`ifdef RAM_FRAME_WRITER_CHECKSUM_EN
        check("t3_chk2", 32'(frame_checksum), 32'h20);
`endif

        // Byte arriving in the write cycle starts the next word
        do_reset();
        send(8'h11); send(8'h22); send(8'h33); send(8'h44); send(8'h55);
        idle(2);
        send(8'h66);
        idle(1);
        send(8'h77); send(8'h88);
        idle(3);
        check("t4_writes", 32'(wr_log.size()), 32'd2);
        expect_log("t4_w0", 0, 2'd0, 32'h11223344);
        expect_log("t4_w1", 1, 2'd1, 32'h55667788);

        // clear drops the partial word and ignores a same-cycle byte
        do_reset();
        send(8'h01); send(8'h02);
        clear = 1'b1; rx_ready = 1'b1; rx_data = 8'h99;
        tick();
        clear = 1'b0; rx_ready = 1'b0;
        send(8'h01); send(8'h02); send(8'h03); send(8'h04);
        idle(3);
        check("t5_writes", 32'(wr_log.size()), 32'd1);
        expect_log("t5_w0", 0, 2'd0, 32'h01020304);

        // clear during the write cycle: strobe completes, address restarts
        wr_log.delete();
        send(8'hA1); send(8'hB2); send(8'hC3); send(8'hD4);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        idle(2);
        check("t6_writes", 32'(wr_log.size()), 32'd1);
        expect_log("t6_w0", 0, 2'd1, 32'hA1B2C3D4);
        check("t6_addr", 32'(write_adress), 32'd0);

        run = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
